cdma_stripe_split: RTL
======================

// Module: cdma_stripe_split
// PURPOSE
// - Command stage directly upstream of the per-channel cdma instances in the multi-channel card path.
// - Splits one user DMA request (addr,len) striped at 2^STRIPE_BITS bytes across N_CHAN memory channels into one sub-request per channel.
// - Emits a mux command (first channel, total beats) for the user-stream sink/src muxes.
// - Merges per-channel completions into one in-order completion per request.
// PARAMETERS
// N_CHAN      4   memory channels, power of 2, >=2; CHAN_BITS=clog2(N_CHAN)
// ADDR_BITS   64  byte address width
// LEN_BITS    28  byte length width
// STRIPE_BITS 6   log2 stripe size in bytes (64 B = one 512-bit beat)
// N_OUTSTAND  8   max requests awaiting completion, power of 2
// PORTS
// aclk             in  1                   clock
// aresetn          in  1                   sync active-low reset
// s_req_valid/ready in/out 1               user request handshake
// s_req_addr       in  ADDR_BITS           byte addr, must be stripe-aligned
// s_req_len        in  LEN_BITS            byte length
// m_req_valid      out N_CHAN              per-channel sub-request valid
// m_req_ready      in  N_CHAN              per-channel ready
// m_req_addr       out N_CHAN*ADDR_BITS    channel-local byte addr
// m_req_len        out N_CHAN*LEN_BITS     channel byte length
// m_mux_valid/ready out/in 1               mux command handshake
// m_mux_id         out CHAN_BITS           channel carrying first beat
// m_mux_len        out LEN_BITS-STRIPE_BITS total beats
// s_done           in  N_CHAN              per-channel completion pulses
// m_done           out 1                   one-cycle pulse per completed request
// BEHAVIOUR
// - Reset: FSM=IDLE, s_req_ready=0 for one cycle then 1, all m_req_valid=0, m_mux_valid=0, m_done=0, counters/queue cleared.
// - IDLE: s_req_ready=1 iff outstanding queue not full; accept registers addr/len -> CALC.
// - CALC (1 cycle): n=ceil(len/2^STRIPE_BITS); s0=addr[STRIPE_BITS+:CHAN_BITS]; q=n>>CHAN_BITS, r=n mod N_CHAN;
//   per c: k=(c-s0) mod N_CHAN; beats_c=q+(k<r); len_c=beats_c<<STRIPE_BITS;
//   addr_c=((addr>>(STRIPE_BITS+CHAN_BITS))+(c<s0))<<STRIPE_BITS; mask[c]=(beats_c!=0). Low addr bits ignored.
// - ISSUE: m_req_valid[c]=mask[c]&~issued[c]; fields stable while valid; channels fire independently, any order, same cycle allowed; m_mux_valid=1 until taken.
//   When all masked channels issued and mux taken: push mask to completion queue -> IDLE. Latency accept->first valid = 2 cycles.
// - len=0: n=0, mask=0, no channel requests, mux cmd with m_mux_len=0 still issued, mask=0 pushed; m_done pulses once it reaches queue head.
// - Completion: per-channel pending counter (width clog2(N_OUTSTAND)+1) increments on s_done[c];
//   when queue head mask has pending[c]>0 for all set bits: m_done=1 one cycle, decrement those counters, pop.
//   s_done and decrement same cycle on one channel -> net 0. One pop per cycle max.
// - Queue full (N_OUTSTAND entries): s_req_ready=0 until a pop; a pop and push in same cycle is legal.
// - Reset mid-operation: all state dropped, in-flight sub-requests abandoned; no m_done for them.
// STRUCTURE
// - Package: CHAN_BITS and beat-count width localparams; struct req_t {addr,len}; struct mux_cmd_t {id,len}.
// - Sub-module: stripe_done_merge (pending counters + mask FIFO + m_done); splitter FSM stays in top.
// TESTING
// - addr=0x0, len=256, N_CHAN=4 -> each channel len=64, addr=0x0; mux id=0, len=4; after 4 s_done -> one m_done.
// - addr=0x80, len=320 -> s0=2, n=5: ch2 128B@0x0, ch3 64B@0x0, ch0 64B@0x40, ch1 64B@0x40; mux id=2, len=5.
// - addr=0x40, len=64 -> only ch1 valid, 64B@0x0; other m_req_valid stay 0; one s_done[1] -> m_done.
// - len=0 -> no m_req_valid, mux len=0, m_done pulses with no s_done input.
// - 8 requests, hold all s_done low -> 9th s_req_ready=0; one set of completions -> ready reasserts; m_done order = accept order even when later dones arrive first.
// - m_req_ready staggered (ch3 first, ch0 last) plus reset asserted during ISSUE -> outputs return to reset values next cycle, no m_done.

Source files
------------

// File: rtl/cdma_stripe_split_pkg.sv
// Shared widths and types for the stripe splitter and its completion merge.
// The channel/width configuration lives here; both modules take their widths from it.
package cdma_stripe_split_pkg;

    localparam int N_CHAN      = 4;
    localparam int ADDR_BITS   = 64;
    localparam int LEN_BITS    = 28;
    localparam int STRIPE_BITS = 6;
    localparam int N_OUTSTAND  = 8;

    localparam int CHAN_BITS = $clog2(N_CHAN);
    localparam int BEAT_BITS = LEN_BITS - STRIPE_BITS;
    localparam int PTR_BITS  = $clog2(N_OUTSTAND);
    localparam int PEND_BITS = PTR_BITS + 1;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [LEN_BITS-1:0]  len;
    } req_t;

    typedef struct packed {
        logic [CHAN_BITS-1:0] id;
        logic [BEAT_BITS-1:0] len;
    } mux_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } split_state_t;

    // Beat count rounded up; one extra bit so a full-length request cannot wrap.
    function automatic logic [BEAT_BITS:0] beats_of(input logic [LEN_BITS-1:0] len);
        return {1'b0, len[LEN_BITS-1:STRIPE_BITS]} +
               {{BEAT_BITS{1'b0}}, |len[STRIPE_BITS-1:0]};
    endfunction

endpackage

// File: rtl/cdma_stripe_split_done_merge.sv
// Per-channel completion counters plus an in-order FIFO of channel masks;
// retires the oldest request once every channel it used has reported done.
module stripe_done_merge
    import cdma_stripe_split_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              push_i,
    input  logic [N_CHAN-1:0] push_mask_i,
    input  logic [N_CHAN-1:0] done_i,
    output logic              full_o,
    output logic              done_o
);

    logic [N_CHAN-1:0]    fifo_q [N_OUTSTAND];
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0]    cnt_q, cnt_d;
    logic [PEND_BITS-1:0] pend_q [N_CHAN];
    logic [PEND_BITS-1:0] pend_d [N_CHAN];
    logic [N_CHAN-1:0]    head;
    logic                 pop;

    always_comb begin
        head = fifo_q[rd_ptr_q];
        pop  = (cnt_q != '0);
        for (int c = 0; c < N_CHAN; c++) begin
            if (head[c] && (pend_q[c] == '0)) pop = 1'b0;
        end
        rd_ptr_d = rd_ptr_q + PTR_BITS'(pop);
        wr_ptr_d = wr_ptr_q + PTR_BITS'(push_i);
        cnt_d    = cnt_q + (PTR_BITS+1)'(push_i) - (PTR_BITS+1)'(pop);
        // A done and a retire on the same channel cancel out.
        for (int c = 0; c < N_CHAN; c++) begin
            pend_d[c] = pend_q[c] + PEND_BITS'(done_i[c]) - PEND_BITS'(pop & head[c]);
        end
    end

    assign full_o = (cnt_q == (PTR_BITS+1)'(N_OUTSTAND));
    assign done_o = pop;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int c = 0; c < N_CHAN; c++) pend_q[c] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            for (int c = 0; c < N_CHAN; c++) pend_q[c] <= pend_d[c];
        end
    end

    always_ff @(posedge aclk) begin
        if (push_i) fifo_q[wr_ptr_q] <= push_mask_i;
    end

endmodule

// File: rtl/cdma_stripe_split.sv
// Splits one striped DMA request into per-channel sub-requests plus a mux command.
//   state    | meaning
//   ST_IDLE  | waiting for a request; ready while completion queue has room
//   ST_CALC  | derive per-channel address/length/mask from the latched request
//   ST_ISSUE | hold sub-requests and mux command until each is taken, then queue mask
module cdma_stripe_split
    import cdma_stripe_split_pkg::*;
(
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        s_req_valid,
    output logic                        s_req_ready,
    input  logic [ADDR_BITS-1:0]        s_req_addr,
    input  logic [LEN_BITS-1:0]         s_req_len,
    output logic [N_CHAN-1:0]           m_req_valid,
    input  logic [N_CHAN-1:0]           m_req_ready,
    output logic [N_CHAN*ADDR_BITS-1:0] m_req_addr,
    output logic [N_CHAN*LEN_BITS-1:0]  m_req_len,
    output logic                        m_mux_valid,
    input  logic                        m_mux_ready,
    output logic [CHAN_BITS-1:0]        m_mux_id,
    output logic [BEAT_BITS-1:0]        m_mux_len,
    input  logic [N_CHAN-1:0]           s_done,
    output logic                        m_done
);

    split_state_t            state_q, state_d;
    logic                    init_q;
    req_t                    in_q, in_d;
    req_t [N_CHAN-1:0]       sub_q, sub_d, calc_sub;
    logic [N_CHAN-1:0]       mask_q, mask_d, calc_mask;
    logic [N_CHAN-1:0]       issued_q, issued_d;
    mux_cmd_t                mux_q, mux_d, calc_mux;
    logic                    mux_taken_q, mux_taken_d;
    logic                    push, q_full;

    logic [BEAT_BITS:0]      n_beats, q_beats, beats;
    logic [CHAN_BITS-1:0]    s0, r_beats, k;
    logic [ADDR_BITS-1:0]    row_base;

    always_comb begin
        n_beats   = beats_of(in_q.len);
        s0        = in_q.addr[STRIPE_BITS +: CHAN_BITS];
        q_beats   = n_beats >> CHAN_BITS;
        r_beats   = n_beats[CHAN_BITS-1:0];
        row_base  = in_q.addr >> (STRIPE_BITS + CHAN_BITS);
        k         = '0;
        beats     = '0;
        calc_sub  = '0;
        calc_mask = '0;
        // Channels before the start channel begin on the next stripe row.
        for (int c = 0; c < N_CHAN; c++) begin
            k     = CHAN_BITS'(c) - s0;
            beats = q_beats + {{BEAT_BITS{1'b0}}, (k < r_beats)};
            calc_sub[c].len  = LEN_BITS'({beats, {STRIPE_BITS{1'b0}}});
            calc_sub[c].addr = (row_base + ADDR_BITS'(CHAN_BITS'(c) < s0)) << STRIPE_BITS;
            calc_mask[c]     = (beats != '0);
        end
        calc_mux.id  = s0;
        calc_mux.len = n_beats[BEAT_BITS-1:0];
    end

    always_comb begin
        state_d     = state_q;
        in_d        = in_q;
        sub_d       = sub_q;
        mask_d      = mask_q;
        issued_d    = issued_q;
        mux_d       = mux_q;
        mux_taken_d = mux_taken_q;
        push        = 1'b0;
        m_req_valid = '0;
        m_mux_valid = 1'b0;
        s_req_ready = init_q && (state_q == ST_IDLE) && !q_full;
        case (state_q)
            ST_IDLE: begin
                if (s_req_valid && s_req_ready) begin
                    in_d.addr = s_req_addr;
                    in_d.len  = s_req_len;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                sub_d       = calc_sub;
                mask_d      = calc_mask;
                mux_d       = calc_mux;
                issued_d    = '0;
                mux_taken_d = 1'b0;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_req_valid = mask_q & ~issued_q;
                m_mux_valid = !mux_taken_q;
                issued_d    = issued_q | (m_req_valid & m_req_ready);
                mux_taken_d = mux_taken_q | (m_mux_valid & m_mux_ready);
                if (((issued_d & mask_q) == mask_q) && mux_taken_d) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            m_req_addr[c*ADDR_BITS +: ADDR_BITS] = sub_q[c].addr;
            m_req_len[c*LEN_BITS +: LEN_BITS]    = sub_q[c].len;
        end
    end

    assign m_mux_id  = mux_q.id;
    assign m_mux_len = mux_q.len;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            init_q      <= 1'b0;
            in_q        <= '0;
            sub_q       <= '0;
            mask_q      <= '0;
            issued_q    <= '0;
            mux_q       <= '0;
            mux_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            in_q        <= in_d;
            sub_q       <= sub_d;
            mask_q      <= mask_d;
            issued_q    <= issued_d;
            mux_q       <= mux_d;
            mux_taken_q <= mux_taken_d;
        end
    end

    stripe_done_merge u_done_merge (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .push_i      (push),
        .push_mask_i (mask_q),
        .done_i      (s_done),
        .full_o      (q_full),
        .done_o      (m_done)
    );

endmodule
